// File: rtl/uart_pkg.sv
// Shared definitions for the UART controller.
// Holds the parity-mode encodings, the RX/TX state encodings, the 16x
// oversample constant and small parity helpers used by RX and TX.
`timescale 1ns/1ps
package uart_pkg;

  localparam int unsigned Oversample = 16;
  localparam int unsigned OsCntW     = $clog2(Oversample);

  typedef enum logic [1:0] {
    ParNone = 2'b00,
    ParOdd  = 2'b01,
    ParEven = 2'b10,
    ParOff  = 2'b11
  } par_mode_e;

  typedef enum logic [2:0] {
    RxIdle,
    RxStart,
    RxData,
    RxParity,
    RxStop,
    RxBrkWait
  } rx_state_e;

  typedef enum logic [2:0] {
    TxIdle,
    TxStart,
    TxData,
    TxParity,
    TxStop1,
    TxStop2
  } tx_state_e;

  function automatic logic par_enabled(par_mode_e mode);
    return (mode == ParOdd) || (mode == ParEven);
  endfunction

  // Parity bit to transmit / expect; narrower data is zero-extended, which
  // leaves the parity unchanged.
  function automatic logic par_bit(logic [7:0] data, par_mode_e mode);
    return (mode == ParOdd) ? ~(^data) : ^data;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// First-word-fall-through FIFO holding received UART entries.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push_i      : write wdata_i (dropped when full unless popping this cycle)
//   wdata_i     : entry to store
//   pop_i       : consumer accepts the head entry
//   rdata_o     : head entry, zero when empty
//   valid_o     : head entry is valid
//   ovf_o       : registered one-cycle pulse when a push was dropped
`timescale 1ns/1ps
module uart_fifo #(
  parameter int unsigned Width = 10,
  parameter int unsigned Depth = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             valid_o,
  output logic             ovf_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic             ovf_q, ovf_d;
  logic             empty, full, do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty.
  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                   (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign do_pop  = pop_i & ~empty;
  assign do_push = push_i & (~full | do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ovf_d  = push_i & full & ~do_pop;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AddrW-1:0]] <= wdata_i;
  end

  assign rdata_o = empty ? '0 : mem_q[rptr_q[AddrW-1:0]];
  assign valid_o = ~empty;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/uart_ctrl.sv
// UART controller: shared baud prescaler, 16x oversampled receiver feeding
// an RX FIFO, and a transmitter with optional parity and two stop bits.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   cfg_div               : prescaler period minus one (bit = 16*(cfg_div+1) clk)
//   cfg_parity, cfg_stop2 : frame format, sampled at frame start
//   uart_rx_i / uart_tx_o : serial lines (idle high)
//   rx_vld_o/rx_rdy_i/rx_data_o/rx_err_o : RX FIFO head, err = {frame, parity}
//   rx_ovf_o              : pulse when a completed frame is dropped on full FIFO
//   tx_vld_i/tx_data_i/tx_rdy_o : transmit handshake
`timescale 1ns/1ps
module uart_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [1:0]        cfg_parity,
  input  logic              cfg_stop2,
  input  logic              uart_rx_i,
  output logic              rx_vld_o,
  input  logic              rx_rdy_i,
  output logic [DATA_W-1:0] rx_data_o,
  output logic [1:0]        rx_err_o,
  output logic              rx_ovf_o,
  input  logic              tx_vld_i,
  input  logic [DATA_W-1:0] tx_data_i,
  output logic              tx_rdy_o,
  output logic              uart_tx_o
);

  localparam logic [OsCntW-1:0] SampleCnt = OsCntW'(Oversample / 2 - 1);
  localparam logic [OsCntW-1:0] LastCnt   = OsCntW'(Oversample - 1);
  localparam logic [OsCntW-1:0] EndCnt    = OsCntW'(Oversample - 2);
  localparam logic [2:0]        LastBit   = 3'(DATA_W - 1);

  // Prescaler; divisor only reloads while both directions are idle so a
  // frame in flight keeps its bit timing.
  logic [DIV_W-1:0] div_q, div_d, presc_q, presc_d;
  logic             tick;

  // RX
  logic              sync1_q, sync2_q, rx_prev_q, rx_s, rx_fall;
  rx_state_e         rx_state_q, rx_state_d;
  logic [OsCntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]        rx_bit_q, rx_bit_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic              rx_par_q, rx_par_d;
  par_mode_e         rx_mode_q, rx_mode_d;
  logic              rx_sample, rx_wrap, rx_push, frame_err, par_err;
  logic [DATA_W+1:0] rx_push_data, fifo_rdata;

  // TX
  tx_state_e         tx_state_q, tx_state_d;
  logic [OsCntW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]        tx_bit_q, tx_bit_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic              tx_par_q, tx_par_d, tx_paren_q, tx_paren_d;
  logic              tx_stop2_q, tx_stop2_d, tx_arm_q, tx_arm_d;
  logic              tx_line_q, tx_line_d, tx_rdy_q, tx_rdy_d;

  assign tick    = (presc_q >= div_q);
  assign presc_d = tick ? '0 : presc_q + 1'b1;
  assign div_d   = (rx_state_q == RxIdle && tx_state_q == TxIdle) ? cfg_div : div_q;

  assign rx_s      = sync2_q;
  assign rx_fall   = rx_prev_q & ~rx_s;
  assign rx_sample = tick & (rx_cnt_q == SampleCnt);
  assign rx_wrap   = tick & (rx_cnt_q == LastCnt);
  assign frame_err = ~rx_s;
  assign par_err   = par_enabled(rx_mode_q) &
                     (rx_par_q != par_bit(8'(rx_shift_q), rx_mode_q));
  assign rx_push_data = {frame_err, par_err, rx_shift_q};

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    rx_mode_d  = rx_mode_q;
    rx_push    = 1'b0;
    if (tick) rx_cnt_d = rx_cnt_q + 1'b1;
    case (rx_state_q)
      RxIdle: begin
        // Oversample count restarts at the falling edge, not at a tick.
        rx_cnt_d = '0;
        if (rx_fall) begin
          rx_state_d = RxStart;
          rx_bit_d   = '0;
          rx_mode_d  = par_mode_e'(cfg_parity);
        end
      end
      RxStart: begin
        if (rx_sample && rx_s) rx_state_d = RxIdle;
        else if (rx_wrap)      rx_state_d = RxData;
      end
      RxData: begin
        if (rx_sample) rx_shift_d = {rx_s, rx_shift_q[DATA_W-1:1]};
        if (rx_wrap) begin
          if (rx_bit_q == LastBit) begin
            rx_state_d = par_enabled(rx_mode_q) ? RxParity : RxStop;
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end
      end
      RxParity: begin
        if (rx_sample) rx_par_d = rx_s;
        if (rx_wrap)   rx_state_d = RxStop;
      end
      RxStop: begin
        // Only the first stop bit is checked; return to idle mid-bit so a
        // following start edge is never missed.
        if (rx_sample) begin
          rx_push    = 1'b1;
          rx_state_d = (frame_err && rx_shift_q == '0) ? RxBrkWait : RxIdle;
        end
      end
      RxBrkWait: if (rx_s) rx_state_d = RxIdle;
      default:   rx_state_d = RxIdle;
    endcase
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_paren_d = tx_paren_q;
    tx_stop2_d = tx_stop2_q;
    tx_arm_d   = tx_arm_q;
    tx_line_d  = tx_line_q;
    tx_rdy_d   = tx_rdy_q;
    case (tx_state_q)
      TxIdle: begin
        tx_line_d = 1'b1;
        if (tx_vld_i && tx_rdy_q) begin
          tx_state_d = TxStart;
          tx_arm_d   = 1'b1;
          tx_rdy_d   = 1'b0;
          tx_bit_d   = '0;
          tx_shift_d = tx_data_i;
          tx_par_d   = par_bit(8'(tx_data_i), par_mode_e'(cfg_parity));
          tx_paren_d = par_enabled(par_mode_e'(cfg_parity));
          tx_stop2_d = cfg_stop2;
        end
      end
      default: begin
        if (tick) begin
          if (tx_arm_q) begin
            // First tick after the handshake opens the start bit.
            tx_arm_d  = 1'b0;
            tx_cnt_d  = '0;
            tx_line_d = 1'b0;
          end else begin
            tx_cnt_d = tx_cnt_q + 1'b1;
            case (tx_state_q)
              TxStart: begin
                if (tx_cnt_q == LastCnt) begin
                  tx_state_d = TxData;
                  tx_line_d  = tx_shift_q[0];
                end
              end
              TxData: begin
                if (tx_cnt_q == LastCnt) begin
                  if (tx_bit_q == LastBit) begin
                    tx_state_d = tx_paren_q ? TxParity : TxStop1;
                    tx_line_d  = tx_paren_q ? tx_par_q : 1'b1;
                  end else begin
                    tx_bit_d   = tx_bit_q + 1'b1;
                    tx_shift_d = tx_shift_q >> 1;
                    tx_line_d  = tx_shift_q[1];
                  end
                end
              end
              TxParity: begin
                if (tx_cnt_q == LastCnt) begin
                  tx_state_d = TxStop1;
                  tx_line_d  = 1'b1;
                end
              end
              // The last stop bit releases ready one tick early; the next
              // frame's start bit then lands exactly on the 16th tick.
              TxStop1: begin
                if (tx_stop2_q) begin
                  if (tx_cnt_q == LastCnt) tx_state_d = TxStop2;
                end else if (tx_cnt_q == EndCnt) begin
                  tx_state_d = TxIdle;
                  tx_rdy_d   = 1'b1;
                end
              end
              TxStop2: begin
                if (tx_cnt_q == EndCnt) begin
                  tx_state_d = TxIdle;
                  tx_rdy_d   = 1'b1;
                end
              end
              default: begin
                tx_state_d = TxIdle;
                tx_rdy_d   = 1'b1;
                tx_line_d  = 1'b1;
              end
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= '0;
      presc_q    <= '0;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
      rx_mode_q  <= ParNone;
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_paren_q <= 1'b0;
      tx_stop2_q <= 1'b0;
      tx_arm_q   <= 1'b0;
      tx_line_q  <= 1'b1;
      tx_rdy_q   <= 1'b1;
    end else begin
      div_q      <= div_d;
      presc_q    <= presc_d;
      sync1_q    <= uart_rx_i;
      sync2_q    <= sync1_q;
      rx_prev_q  <= sync2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_par_q   <= rx_par_d;
      rx_mode_q  <= rx_mode_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_paren_q <= tx_paren_d;
      tx_stop2_q <= tx_stop2_d;
      tx_arm_q   <= tx_arm_d;
      tx_line_q  <= tx_line_d;
      tx_rdy_q   <= tx_rdy_d;
    end
  end

  uart_fifo #(
    .Width (DATA_W + 2),
    .Depth (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rx_push),
    .wdata_i (rx_push_data),
    .pop_i   (rx_rdy_i),
    .rdata_o (fifo_rdata),
    .valid_o (rx_vld_o),
    .ovf_o   (rx_ovf_o)
  );

  assign rx_data_o = fifo_rdata[DATA_W-1:0];
  assign rx_err_o  = fifo_rdata[DATA_W+1:DATA_W];
  assign tx_rdy_o  = tx_rdy_q;
  assign uart_tx_o = tx_line_q;

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed self-checking bench for uart_ctrl (FIFO_DEPTH = 4).
`timescale 1ns/1ps
module tb_uart_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cfg_div;
  logic [1:0]  cfg_parity;
  logic        cfg_stop2;
  logic        uart_rx, rx_drv, loop_en;
  logic        rx_vld_o, rx_rdy_i, rx_ovf_o;
  logic [7:0]  rx_data_o;
  logic [1:0]  rx_err_o;
  logic        tx_vld_i, tx_rdy_o, uart_tx_o;
  logic [7:0]  tx_data_i;

  int n_checks = 0;
  int n_err    = 0;
  int ovf_cnt  = 0;

  always #5 clk = ~clk;

  assign uart_rx = loop_en ? uart_tx_o : rx_drv;

  always @(posedge clk) if (rx_ovf_o) ovf_cnt <= ovf_cnt + 1;

  uart_ctrl #(
    .DATA_W     (8),
    .FIFO_DEPTH (4),
    .DIV_W      (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_div    (cfg_div),
    .cfg_parity (cfg_parity),
    .cfg_stop2  (cfg_stop2),
    .uart_rx_i  (uart_rx),
    .rx_vld_o   (rx_vld_o),
    .rx_rdy_i   (rx_rdy_i),
    .rx_data_o  (rx_data_o),
    .rx_err_o   (rx_err_o),
    .rx_ovf_o   (rx_ovf_o),
    .tx_vld_i   (tx_vld_i),
    .tx_data_i  (tx_data_i),
    .tx_rdy_o   (tx_rdy_o),
    .uart_tx_o  (uart_tx_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tx_send(input logic [7:0] d);
    int n = 0;
    while (!tx_rdy_o && n < 5000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 5000) check_eq("tx_rdy_timeout", 32'd0, 32'd1);
    tx_vld_i  = 1'b1;
    tx_data_i = d;
    @(negedge clk);
    tx_vld_i  = 1'b0;
  endtask

  // Drive n bits LSB first, 16 clk each (cfg_div = 0), then idle high.
  task automatic drive_bits(input logic [11:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rx_drv = bits[i];
      repeat (16) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic rx_send(input logic [7:0] d);
    logic [11:0] bits;
    bits = {2'b11, 1'b1, d, 1'b0};
    drive_bits(bits, 10);
  endtask

  task automatic pop_check(input string tag, input logic [7:0] d, input logic [1:0] e);
    int n = 0;
    while (!rx_vld_o && n < 5000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 5000) begin
      check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check_eq({tag, "_data"}, rx_data_o, d);
      check_eq({tag, "_err"}, rx_err_o, e);
      rx_rdy_i = 1'b1;
      @(negedge clk);
      rx_rdy_i = 1'b0;
    end
  endtask

  initial begin
    logic [9:0]  frame;
    logic [11:0] bits;
    int          rdy_low;
    int          ovf_before;

    rst_n      = 1'b0;
    cfg_div    = 16'd0;
    cfg_parity = 2'b00;
    cfg_stop2  = 1'b0;
    rx_drv     = 1'b1;
    loop_en    = 1'b0;
    rx_rdy_i   = 1'b0;
    tx_vld_i   = 1'b0;
    tx_data_i  = 8'h00;
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("rst_tx", uart_tx_o, 1);
    check_eq("rst_tx_rdy", tx_rdy_o, 1);
    check_eq("rst_rx_vld", rx_vld_o, 0);
    check_eq("rst_ovf", rx_ovf_o, 0);
    check_eq("rst_rx_data", rx_data_o, 0);
    check_eq("rst_rx_err", rx_err_o, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // TX 0xA5, cfg_div=0, no parity, one stop
    frame = {1'b1, 8'hA5, 1'b0};
    tx_send(8'hA5);
    rdy_low = 0;
    for (int k = 1; k <= 170; k++) begin
      if (!tx_rdy_o) rdy_low++;
      if (k == 1) check_eq("tx_before_start", uart_tx_o, 1);
      else if (k <= 161 && ((k - 2) % 16 == 0 || (k - 2) % 16 == 15))
        check_eq($sformatf("tx_a5_bit%0d_c%0d", (k - 2) / 16, (k - 2) % 16),
                 uart_tx_o, frame[(k - 2) / 16]);
      @(negedge clk);
    end
    check_eq("tx_rdy_low_clks", rdy_low, 160);

    // Loopback, cfg_div=3, odd parity, two stop bits
    cfg_div    = 16'd3;
    cfg_parity = 2'b01;
    cfg_stop2  = 1'b1;
    loop_en    = 1'b1;
    repeat (4) @(negedge clk);
    tx_send(8'h00);
    rdy_low = 0;
    while (!tx_rdy_o && rdy_low < 3000) begin
      rdy_low++;
      @(negedge clk);
    end
    // 12 bits * 16 ticks * 4 clk, minus up to 3 clk of prescaler phase
    check_eq("loop_frame_len", (rdy_low >= 765 && rdy_low <= 768), 1);
    tx_send(8'hFF);
    tx_send(8'h3C);
    pop_check("loop_00", 8'h00, 2'b00);
    pop_check("loop_ff", 8'hFF, 2'b00);
    pop_check("loop_3c", 8'h3C, 2'b00);
    repeat (40 * 16) @(negedge clk);
    check_eq("loop_empty", rx_vld_o, 0);

    // RX 0x55, even parity with inverted parity bit
    loop_en    = 1'b0;
    cfg_div    = 16'd0;
    cfg_parity = 2'b10;
    cfg_stop2  = 1'b0;
    repeat (8) @(negedge clk);
    bits = {1'b1, 1'b1, 1'b1, 8'h55, 1'b0};
    drive_bits(bits, 11);
    pop_check("par_err", 8'h55, 2'b01);

    // Low glitch of 5 clk is rejected, then a clean frame is received
    cfg_parity = 2'b00;
    rx_drv = 1'b0;
    repeat (5) @(negedge clk);
    rx_drv = 1'b1;
    repeat (100) @(negedge clk);
    check_eq("glitch_no_push", rx_vld_o, 0);
    rx_send(8'h3C);
    pop_check("after_glitch", 8'h3C, 2'b00);

    // Break: one 0x00 entry with frame error, nothing more while low
    rx_drv = 1'b0;
    repeat (200) @(negedge clk);
    pop_check("break", 8'h00, 2'b10);
    repeat (200) @(negedge clk);
    check_eq("break_hold", rx_vld_o, 0);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("break_release", rx_vld_o, 0);
    rx_send(8'hA7);
    pop_check("after_break", 8'hA7, 2'b00);

    // Overflow: 6 frames into a 4-deep FIFO
    ovf_before = ovf_cnt;
    rx_send(8'h11);
    rx_send(8'h22);
    rx_send(8'h33);
    rx_send(8'h44);
    rx_send(8'h55);
    rx_send(8'h66);
    repeat (20) @(negedge clk);
    check_eq("ovf_pulses", ovf_cnt - ovf_before, 2);
    pop_check("ovf_q0", 8'h11, 2'b00);
    pop_check("ovf_q1", 8'h22, 2'b00);
    pop_check("ovf_q2", 8'h33, 2'b00);
    pop_check("ovf_q3", 8'h44, 2'b00);
    repeat (3) @(negedge clk);
    check_eq("ovf_drained", rx_vld_o, 0);

    // Reset in the middle of TX data bits, then a clean loopback frame
    loop_en = 1'b1;
    repeat (4) @(negedge clk);
    tx_send(8'h5A);
    repeat (16 * 5) @(negedge clk);
    check_eq("mid_tx_busy", tx_rdy_o, 0);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_tx", uart_tx_o, 1);
    check_eq("mid_rst_rdy", tx_rdy_o, 1);
    check_eq("mid_rst_vld", rx_vld_o, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tx_send(8'h96);
    pop_check("after_rst", 8'h96, 2'b00);
    repeat (200) @(negedge clk);
    check_eq("after_rst_empty", rx_vld_o, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

endmodule
